// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : Execute stage with operand forwarding, plus the EX/MEM register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_mem_stage #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          stall,
   input  logic          WBregwr,
   input  logic          WBregomem,
   input  logic          MEMwr,
   input  logic          MEMread,
   input  logic          EXalusrc,
   input  logic [2:0]    EXaluctrl,
   input  logic          REGdst,
   input  logic [DW-1:0] readDATA1,
   input  logic [DW-1:0] readDATA2,
   input  logic [DW-1:0] constant,
   input  logic [AW-1:0] writeREG2,
   input  logic [AW-1:0] writeREG3,
   input  logic [AW-1:0] ID_EX_readREG1,
   input  logic [AW-1:0] ID_EX_readREG2,
   input  logic          MEM_WB_regwr,
   input  logic [AW-1:0] MEM_WB_writeREG,
   input  logic [DW-1:0] MEM_WB_data,
   output logic          EX_MEM_WBregwr,
   output logic          EX_MEM_WBregomem,
   output logic          EX_MEM_MEMwr,
   output logic          EX_MEM_MEMread,
   output logic [DW-1:0] EX_MEM_aluout,
   output logic [DW-1:0] EX_MEM_storedata,
   output logic [AW-1:0] EX_MEM_writeREG,
   output logic          EX_MEM_zero,
   output logic          EX_MEM_ovf,
   output logic [1:0]    fwdA,
   output logic [1:0]    fwdB
);

   localparam logic [2:0] c_ALU_ADD  = 3'b000;
   localparam logic [2:0] c_ALU_SUB  = 3'b001;
   localparam logic [2:0] c_ALU_AND  = 3'b010;
   localparam logic [2:0] c_ALU_OR   = 3'b011;
   localparam logic [2:0] c_ALU_SLT  = 3'b100;
   localparam logic [2:0] c_ALU_XOR  = 3'b101;
   localparam logic [2:0] c_ALU_NOR  = 3'b110;

   localparam logic [1:0] c_FWD_NONE = 2'b00;
   localparam logic [1:0] c_FWD_WB   = 2'b01;
   localparam logic [1:0] c_FWD_MEM  = 2'b10;

   logic          r_wbregwr;
   logic          r_wbregomem;
   logic          r_memwr;
   logic          r_memread;
   logic [DW-1:0] r_aluout;
   logic [DW-1:0] r_storedata;
   logic [AW-1:0] r_writereg;
   logic          r_zero;
   logic          r_ovf;

   logic [1:0]    w_fwd_a;
   logic [1:0]    w_fwd_b;
   logic [DW-1:0] w_opa;
   logic [DW-1:0] w_fwdb_val;
   logic [DW-1:0] w_opb;
   logic [DW-1:0] w_sum;
   logic [DW-1:0] w_diff;
   logic [DW-1:0] w_result;
   logic          w_ovf;
   logic          w_lt;
   logic [AW-1:0] w_dest;

   // Loads in EX/MEM are excluded: their data does not exist until MEM completes.
   function automatic logic [1:0] fwd_sel(
      input logic          rst_i,
      input logic [AW-1:0] src,
      input logic          em_wr,
      input logic          em_mem,
      input logic [AW-1:0] em_reg,
      input logic          wb_wr,
      input logic [AW-1:0] wb_reg
   );
      logic [1:0] sel;
      sel = c_FWD_NONE;
      if (rst_i)
         sel = c_FWD_NONE;
      else if (em_wr && !em_mem && (em_reg != '0) && (em_reg == src))
         sel = c_FWD_MEM;
      else if (wb_wr && (wb_reg != '0) && (wb_reg == src))
         sel = c_FWD_WB;
      return sel;
   endfunction

   always_comb begin
      w_fwd_a = fwd_sel(rst, ID_EX_readREG1, r_wbregwr, r_wbregomem, r_writereg,
                        MEM_WB_regwr, MEM_WB_writeREG);
      w_fwd_b = fwd_sel(rst, ID_EX_readREG2, r_wbregwr, r_wbregomem, r_writereg,
                        MEM_WB_regwr, MEM_WB_writeREG);
   end

   always_comb begin
      case (w_fwd_a)
         c_FWD_MEM: w_opa = r_aluout;
         c_FWD_WB:  w_opa = MEM_WB_data;
         default:   w_opa = readDATA1;
      endcase
      case (w_fwd_b)
         c_FWD_MEM: w_fwdb_val = r_aluout;
         c_FWD_WB:  w_fwdb_val = MEM_WB_data;
         default:   w_fwdb_val = readDATA2;
      endcase
      w_opb  = EXalusrc ? constant : w_fwdb_val;
      w_dest = REGdst ? writeREG3 : writeREG2;
   end

   always_comb begin
      w_sum  = w_opa + w_opb;
      w_diff = w_opa - w_opb;
      w_lt   = ($signed(w_opa) < $signed(w_opb));
      w_ovf  = 1'b0;
      case (EXaluctrl)
         c_ALU_ADD: begin
            w_result = w_sum;
            w_ovf    = (w_opa[DW-1] == w_opb[DW-1]) && (w_sum[DW-1] != w_opa[DW-1]);
         end
         c_ALU_SUB: begin
            w_result = w_diff;
            w_ovf    = (w_opa[DW-1] != w_opb[DW-1]) && (w_diff[DW-1] != w_opa[DW-1]);
         end
         c_ALU_AND: w_result = w_opa & w_opb;
         c_ALU_OR:  w_result = w_opa | w_opb;
         c_ALU_SLT: w_result = {{(DW-1){1'b0}}, w_lt};
         c_ALU_XOR: w_result = w_opa ^ w_opb;
         c_ALU_NOR: w_result = ~(w_opa | w_opb);
         default:   w_result = w_opb;
      endcase
   end

   // Flush kills only the side-effecting controls and flags; datapath still loads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wbregwr   <= 1'b0;
         r_wbregomem <= 1'b0;
         r_memwr     <= 1'b0;
         r_memread   <= 1'b0;
         r_aluout    <= '0;
         r_storedata <= '0;
         r_writereg  <= '0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (flush) begin
         r_wbregwr   <= 1'b0;
         r_wbregomem <= 1'b0;
         r_memwr     <= 1'b0;
         r_memread   <= 1'b0;
         r_aluout    <= w_result;
         r_storedata <= w_fwdb_val;
         r_writereg  <= w_dest;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (!stall) begin
         r_wbregwr   <= WBregwr;
         r_wbregomem <= WBregomem;
         r_memwr     <= MEMwr;
         r_memread   <= MEMread;
         r_aluout    <= w_result;
         r_storedata <= w_fwdb_val;
         r_writereg  <= w_dest;
         r_zero      <= (w_result == '0);
         r_ovf       <= w_ovf;
      end
   end

   assign EX_MEM_WBregwr   = r_wbregwr;
   assign EX_MEM_WBregomem = r_wbregomem;
   assign EX_MEM_MEMwr     = r_memwr;
   assign EX_MEM_MEMread   = r_memread;
   assign EX_MEM_aluout    = r_aluout;
   assign EX_MEM_storedata = r_storedata;
   assign EX_MEM_writeREG  = r_writereg;
   assign EX_MEM_zero      = r_zero;
   assign EX_MEM_ovf       = r_ovf;
   assign fwdA             = w_fwd_a;
   assign fwdB             = w_fwd_b;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// Module   : tb_ex_mem_stage
// Purpose  : Directed self-checking bench for ex_mem_stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;

   localparam int DW = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush, stall;
   logic          WBregwr, WBregomem, MEMwr, MEMread, EXalusrc, REGdst;
   logic [2:0]    EXaluctrl;
   logic [DW-1:0] readDATA1, readDATA2, constant, MEM_WB_data;
   logic [AW-1:0] writeREG2, writeREG3, ID_EX_readREG1, ID_EX_readREG2, MEM_WB_writeREG;
   logic          MEM_WB_regwr;
   logic          EX_MEM_WBregwr, EX_MEM_WBregomem, EX_MEM_MEMwr, EX_MEM_MEMread;
   logic [DW-1:0] EX_MEM_aluout, EX_MEM_storedata;
   logic [AW-1:0] EX_MEM_writeREG;
   logic          EX_MEM_zero, EX_MEM_ovf;
   logic [1:0]    fwdA, fwdB;

   int errors = 0;
   int checks = 0;

   ex_mem_stage #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .WBregwr(WBregwr), .WBregomem(WBregomem), .MEMwr(MEMwr), .MEMread(MEMread),
      .EXalusrc(EXalusrc), .EXaluctrl(EXaluctrl), .REGdst(REGdst),
      .readDATA1(readDATA1), .readDATA2(readDATA2), .constant(constant),
      .writeREG2(writeREG2), .writeREG3(writeREG3),
      .ID_EX_readREG1(ID_EX_readREG1), .ID_EX_readREG2(ID_EX_readREG2),
      .MEM_WB_regwr(MEM_WB_regwr), .MEM_WB_writeREG(MEM_WB_writeREG),
      .MEM_WB_data(MEM_WB_data),
      .EX_MEM_WBregwr(EX_MEM_WBregwr), .EX_MEM_WBregomem(EX_MEM_WBregomem),
      .EX_MEM_MEMwr(EX_MEM_MEMwr), .EX_MEM_MEMread(EX_MEM_MEMread),
      .EX_MEM_aluout(EX_MEM_aluout), .EX_MEM_storedata(EX_MEM_storedata),
      .EX_MEM_writeREG(EX_MEM_writeREG), .EX_MEM_zero(EX_MEM_zero),
      .EX_MEM_ovf(EX_MEM_ovf), .fwdA(fwdA), .fwdB(fwdB)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic defaults();
      flush = 0; stall = 0;
      WBregwr = 0; WBregomem = 0; MEMwr = 0; MEMread = 0;
      EXalusrc = 0; EXaluctrl = 3'b000; REGdst = 0;
      readDATA1 = '0; readDATA2 = '0; constant = '0;
      writeREG2 = 3'd1; writeREG3 = 3'd1;
      ID_EX_readREG1 = 3'd1; ID_EX_readREG2 = 3'd2;
      MEM_WB_regwr = 0; MEM_WB_writeREG = '0; MEM_WB_data = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".wbregwr"},   {31'd0, EX_MEM_WBregwr},   32'd0);
      check({tag, ".wbregomem"}, {31'd0, EX_MEM_WBregomem}, 32'd0);
      check({tag, ".memwr"},     {31'd0, EX_MEM_MEMwr},     32'd0);
      check({tag, ".memread"},   {31'd0, EX_MEM_MEMread},   32'd0);
      check({tag, ".aluout"},    {24'd0, EX_MEM_aluout},    32'd0);
      check({tag, ".storedata"}, {24'd0, EX_MEM_storedata}, 32'd0);
      check({tag, ".writereg"},  {29'd0, EX_MEM_writeREG},  32'd0);
      check({tag, ".zero"},      {31'd0, EX_MEM_zero},      32'd0);
      check({tag, ".ovf"},       {31'd0, EX_MEM_ovf},       32'd0);
      check({tag, ".fwdA"},      {30'd0, fwdA},             32'd0);
   endtask

   // Register-operand ALU vector, no forwarding active.
   task automatic alu_vec(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] res, input logic ovf);
      defaults();
      EXaluctrl = op; readDATA1 = a; readDATA2 = b;
      tick();
      check({tag, ".res"},  {24'd0, EX_MEM_aluout},    {24'd0, res});
      check({tag, ".ovf"},  {31'd0, EX_MEM_ovf},       {31'd0, ovf});
      check({tag, ".zero"}, {31'd0, EX_MEM_zero},      {31'd0, (res == 8'h00)});
      check({tag, ".sd"},   {24'd0, EX_MEM_storedata}, {24'd0, b});
   endtask

   initial begin
      defaults();
      rst = 1;
      #2;
      check_all_zero("reset0");
      tick(); tick();
      rst = 0;

      // Async reset mid-cycle after a value has been registered
      defaults();
      EXalusrc = 1; EXaluctrl = 3'b111; constant = 8'h5A; WBregwr = 1; writeREG2 = 3'd7;
      tick();
      check("pre_rst.aluout", {24'd0, EX_MEM_aluout}, 32'h5A);
      check("pre_rst.wbregwr", {31'd0, EX_MEM_WBregwr}, 32'd1);
      #2 rst = 1;
      #1;
      check_all_zero("async_rst");
      #1 rst = 0;

      // Plain ALU
      defaults();
      readDATA1 = 8'h70; readDATA2 = 8'h20; REGdst = 1; writeREG3 = 3'd5;
      tick();
      check("add.res",  {24'd0, EX_MEM_aluout},   32'h90);
      check("add.ovf",  {31'd0, EX_MEM_ovf},      32'd1);
      check("add.zero", {31'd0, EX_MEM_zero},     32'd0);
      check("add.dst",  {29'd0, EX_MEM_writeREG}, 32'd5);
      alu_vec("sub0",  3'b001, 8'h20, 8'h20, 8'h00, 1'b0);
      alu_vec("subov", 3'b001, 8'h80, 8'h01, 8'h7F, 1'b1);
      alu_vec("subo2", 3'b001, 8'h7F, 8'hFF, 8'h80, 1'b1);
      alu_vec("addw",  3'b000, 8'hF0, 8'h10, 8'h00, 1'b0);
      alu_vec("and",   3'b010, 8'hC5, 8'h0F, 8'h05, 1'b0);
      alu_vec("or",    3'b011, 8'hC5, 8'h0F, 8'hCF, 1'b0);
      alu_vec("slt1",  3'b100, 8'hFF, 8'h01, 8'h01, 1'b0);
      alu_vec("slt0",  3'b100, 8'h01, 8'hFF, 8'h00, 1'b0);
      alu_vec("xor",   3'b101, 8'hC5, 8'h0F, 8'hCA, 1'b0);
      alu_vec("nor",   3'b110, 8'hC5, 8'h0F, 8'h30, 1'b0);
      alu_vec("pass",  3'b111, 8'hC5, 8'h0F, 8'h0F, 1'b0);

      // EX/MEM forwarding beats MEM/WB
      defaults();
      WBregwr = 1; writeREG2 = 3'd3; readDATA1 = 8'h10; readDATA2 = 8'h01;
      tick();
      check("r3.aluout", {24'd0, EX_MEM_aluout}, 32'h11);
      defaults();
      ID_EX_readREG1 = 3'd3; readDATA1 = 8'hFF;
      MEM_WB_regwr = 1; MEM_WB_writeREG = 3'd3; MEM_WB_data = 8'h22;
      EXalusrc = 1; constant = 8'h07; EXaluctrl = 3'b011;
      #1;
      check("fwd_em.fwdA", {30'd0, fwdA}, 32'd2);
      check("fwd_em.fwdB", {30'd0, fwdB}, 32'd0);
      tick();
      check("fwd_em.or", {24'd0, EX_MEM_aluout}, 32'h17);

      // MEM/WB forwarding of store data
      defaults();
      MEM_WB_regwr = 1; MEM_WB_writeREG = 3'd2; MEM_WB_data = 8'h3C;
      ID_EX_readREG2 = 3'd2; readDATA2 = 8'h99; readDATA1 = 8'h10;
      MEMwr = 1; EXalusrc = 1; constant = 8'h04;
      #1;
      check("fwd_wb.fwdB", {30'd0, fwdB}, 32'd1);
      tick();
      check("fwd_wb.sd",    {24'd0, EX_MEM_storedata}, 32'h3C);
      check("fwd_wb.addr",  {24'd0, EX_MEM_aluout},    32'h14);
      check("fwd_wb.memwr", {31'd0, EX_MEM_MEMwr},     32'd1);
      // r0 never forwards
      defaults();
      MEM_WB_regwr = 1; MEM_WB_writeREG = 3'd0; MEM_WB_data = 8'h3C;
      ID_EX_readREG2 = 3'd0; readDATA2 = 8'h99;
      MEMwr = 1; EXalusrc = 1; constant = 8'h04;
      #1;
      check("r0.fwdB", {30'd0, fwdB}, 32'd0);
      tick();
      check("r0.sd", {24'd0, EX_MEM_storedata}, 32'h99);

      // Load result in EX/MEM is not forwarded
      defaults();
      WBregwr = 1; WBregomem = 1; MEMread = 1; writeREG2 = 3'd4;
      EXalusrc = 1; constant = 8'h08; readDATA1 = 8'h10;
      tick();
      check("ld.wbregomem", {31'd0, EX_MEM_WBregomem}, 32'd1);
      check("ld.memread",   {31'd0, EX_MEM_MEMread},   32'd1);
      defaults();
      ID_EX_readREG1 = 3'd4; readDATA1 = 8'h33; EXalusrc = 1; constant = 8'h00;
      #1;
      check("ld.fwdA", {30'd0, fwdA}, 32'd0);
      tick();
      check("ld.opA", {24'd0, EX_MEM_aluout}, 32'h33);

      // Stall holds for three cycles
      defaults();
      WBregwr = 1; writeREG2 = 3'd6; readDATA1 = 8'h01; readDATA2 = 8'h02;
      tick();
      check("pre_stall.aluout", {24'd0, EX_MEM_aluout}, 32'h03);
      for (int i = 0; i < 3; i++) begin
         defaults();
         stall = 1; readDATA1 = 8'h40 + 8'(i); readDATA2 = 8'h05; writeREG2 = 3'd2; MEMwr = 1;
         tick();
         check("stall.aluout",  {24'd0, EX_MEM_aluout},   32'h03);
         check("stall.wbregwr", {31'd0, EX_MEM_WBregwr},  32'd1);
         check("stall.dst",     {29'd0, EX_MEM_writeREG}, 32'd6);
         check("stall.memwr",   {31'd0, EX_MEM_MEMwr},    32'd0);
      end

      // Flush clears controls, datapath still loads
      defaults();
      flush = 1; MEMwr = 1; WBregwr = 1; MEMread = 1; readDATA1 = 8'h40; readDATA2 = 8'h01;
      tick();
      check("flush.memwr",   {31'd0, EX_MEM_MEMwr},   32'd0);
      check("flush.wbregwr", {31'd0, EX_MEM_WBregwr}, 32'd0);
      check("flush.memread", {31'd0, EX_MEM_MEMread}, 32'd0);
      check("flush.aluout",  {24'd0, EX_MEM_aluout},  32'h41);

      // Flush wins over stall
      defaults();
      flush = 1; stall = 1; MEMwr = 1; WBregwr = 1; WBregomem = 1;
      readDATA1 = 8'h50; readDATA2 = 8'h01;
      tick();
      check("fs.memwr",     {31'd0, EX_MEM_MEMwr},     32'd0);
      check("fs.wbregwr",   {31'd0, EX_MEM_WBregwr},   32'd0);
      check("fs.wbregomem", {31'd0, EX_MEM_WBregomem}, 32'd0);
      check("fs.aluout",    {24'd0, EX_MEM_aluout},    32'h51);

      // Normal load resumes
      defaults();
      WBregwr = 1; MEMwr = 1; readDATA1 = 8'h02; readDATA2 = 8'h02; EXaluctrl = 3'b001;
      tick();
      check("resume.wbregwr", {31'd0, EX_MEM_WBregwr}, 32'd1);
      check("resume.memwr",   {31'd0, EX_MEM_MEMwr},   32'd1);
      check("resume.zero",    {31'd0, EX_MEM_zero},    32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Execute stage plus EX/MEM pipeline register of the 8-bit five-stage CPU.
- Consumes the ID/EX register outputs.
- Resolves RAW data hazards by forwarding from EX/MEM and MEM/WB.
- Performs the ALU operation.
- Registers results, store data, destination register and MEM/WB control bits for the memory stage.

Parameters:
DW, 8, datapath width
AW, 3, register-address width (8 registers, r0 reads as zero)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  insert bubble into EX/MEM on next edge
stall  in  1  hold EX/MEM contents
WBregwr  in  1  ID/EX register-write enable
WBregomem  in  1  ID/EX write-back selects memory data
MEMwr  in  1  ID/EX memory write
MEMread  in  1  ID/EX memory read
EXalusrc  in  1  1 = ALU B operand is constant
EXaluctrl  in  3  ALU operation
REGdst  in  1  1 = destination is writeREG3, 0 = writeREG2
readDATA1  in  DW  rs value from register file
readDATA2  in  DW  rt value from register file
constant  in  DW  sign-extended immediate
writeREG2  in  AW  rt field
writeREG3  in  AW  rd field
ID_EX_readREG1  in  AW  rs address
ID_EX_readREG2  in  AW  rt address
MEM_WB_regwr  in  1  write-back stage write enable
MEM_WB_writeREG  in  AW  write-back destination
MEM_WB_data  in  DW  write-back value
EX_MEM_WBregwr  out  1  registered
EX_MEM_WBregomem  out  1  registered
EX_MEM_MEMwr  out  1  registered
EX_MEM_MEMread  out  1  registered
EX_MEM_aluout  out  DW  registered ALU result / memory address
EX_MEM_storedata  out  DW  registered forwarded rt value
EX_MEM_writeREG  out  AW  registered destination register
EX_MEM_zero  out  1  registered, 1 when ALU result == 0
EX_MEM_ovf  out  1  registered signed overflow (add/sub only, else 0)
fwdA  out  2  combinational forward select A (debug/verification)
fwdB  out  2  combinational forward select B

Behaviour:
- Reset (async, rst=1): all EX_MEM_* outputs = 0, independent of clk; released on the first edge after rst falls.
- Forwarding A (fwdA), same rule for B using ID_EX_readREG2:
  - 2'b10 when EX_MEM_WBregwr=1, EX_MEM_WBregomem=0, EX_MEM_writeREG≠0 and EX_MEM_writeREG==ID_EX_readREG1.
  - Else 2'b01 when MEM_WB_regwr=1, MEM_WB_writeREG≠0 and MEM_WB_writeREG==ID_EX_readREG1.
  - Else 2'b00.
  - EX/MEM has priority over MEM/WB.
  - A load in EX/MEM is never forwarded; load-use stalling is the hazard unit's job.
  - fwdA/fwdB are forced to 2'b00 while rst=1.
- Operands:
  - opA = selected readDATA1 / EX_MEM_aluout / MEM_WB_data.
  - fwdB_val = same selection on readDATA2.
  - opB = constant if EXalusrc else fwdB_val.
- ALU (EXaluctrl), result truncated to DW:
  - 000 add
  - 001 sub (A−B)
  - 010 and
  - 011 or
  - 100 slt (signed; result 1 or 0)
  - 101 xor
  - 110 nor
  - 111 pass opB
- Overflow: add sets ovf when operand signs are equal and the result sign differs. sub sets ovf when operand signs differ and the result sign differs from A. All other ops give ovf=0.
- Destination: writeREG3 if REGdst else writeREG2.
- Latency: 1 cycle; inputs sampled at edge N appear on EX_MEM_* after edge N.
- On each rising edge, priority flush > stall > load:
  - flush=1: WBregwr, WBregomem, MEMwr, MEMread, zero and ovf = 0. aluout, storedata and writeREG load normally.
  - stall=1: all EX_MEM_* hold.
  - Otherwise: load all computed values.
- flush and stall both 1: flush wins.
- Storedata always carries fwdB_val, never the constant.
- Reset asserted mid-pipeline clears instantly; an in-flight write-back is lost, which is intended.

Test Plan:
1. Reset: drive rst=1 mid-cycle with EX_MEM_aluout=0x5A -> all EX_MEM_* = 0 immediately, before the next clk edge.
2. Plain ALU: readDATA1=0x70, readDATA2=0x20, aluctrl=000, alusrc=0, REGdst=1, writeREG3=5 -> after one edge aluout=0x90, ovf=1, zero=0, writeREG=5. Repeat with sub and 0x20−0x20 -> aluout=0x00, zero=1.
3. EX/MEM forwarding with priority:
   - Cycle 1: add writes r3=0x11. Cycle 2: ID_EX_readREG1=3, readDATA1=0xFF, and MEM_WB also targets r3 with 0x22.
   - Required: fwdA=10 and opA=0x11. With aluctrl=111 and constant=0x07, alusrc=1 -> aluout=0x07, and or (010→011) gives 0x17.
4. MEM/WB forwarding and r0:
   - MEM_WB_regwr=1, MEM_WB_writeREG=2, data=0x3C, readREG2=2, store (MEMwr=1, alusrc=1) -> storedata=0x3C, fwdB=01.
   - Same with writeREG=0 -> fwdB=00 and storedata=readDATA2.
5. Load not forwarded: previous instruction has WBregomem=1, WBregwr=1, writeREG=4; current readREG1=4 -> fwdA=00, opA=readDATA1.
6. Flush/stall:
   - stall=1 for 3 cycles with changing inputs -> outputs unchanged.
   - flush=1 with MEMwr=1, WBregwr=1 -> EX_MEM_MEMwr=0, EX_MEM_WBregwr=0.
   - flush and stall both 1 -> control bits = 0.
